// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with a single-block refill over a read/busywait handshake.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_direct_mapped #(
    parameter int unsigned NUM_BLOCKS      = 8,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned ADDR_W          = 10
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic [ADDR_W-1:0]                             PC_ADDR,
    output logic [31:0]                                   INSTRUCTION,
    output logic                                          BUSYWAIT,
    output logic                                          MEM_READ,
    output logic [ADDR_W-2-$clog2(WORDS_PER_BLOCK)-1:0]   MEM_ADDRESS,
    input  logic [32*WORDS_PER_BLOCK-1:0]                 MEM_READDATA,
    input  logic                                          MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                                   HIT_COUNT,
    output logic [15:0]                                   MISS_COUNT
`endif
);

    localparam int unsigned IW  = $clog2(NUM_BLOCKS);
    localparam int unsigned OW  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BAW = ADDR_W - 2 - OW;
    localparam int unsigned TW  = BAW - IW;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   mem_read_q;
    logic                   first_q;
    logic [BAW-1:0]         fill_addr_q;
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [TW-1:0]          tag_q  [NUM_BLOCKS];
    logic [31:0]            data_q [NUM_BLOCKS][WORDS_PER_BLOCK];

    logic [OW-1:0]          pc_off;
    logic [IW-1:0]          pc_idx;
    logic [TW-1:0]          pc_tag;
    logic [BAW-1:0]         pc_blk;
    logic [IW-1:0]          fill_idx;
    logic [TW-1:0]          fill_tag;
    logic                   hit;
    logic                   fill_done;
    logic                   line_we;
    logic                   unused_pc_lsb;

    // Address decode for the live PC and for the latched fill address
    assign pc_off        = PC_ADDR[OW+1:2];
    assign pc_idx        = PC_ADDR[OW+IW+1:OW+2];
    assign pc_tag        = PC_ADDR[ADDR_W-1:OW+IW+2];
    assign pc_blk        = PC_ADDR[ADDR_W-1:OW+2];
    assign fill_idx      = fill_addr_q[IW-1:0];
    assign fill_tag      = fill_addr_q[BAW-1:IW];
    assign unused_pc_lsb = ^PC_ADDR[1:0];

    assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign INSTRUCTION = data_q[pc_idx][pc_off];
    assign BUSYWAIT    = (state_q != S_IDLE) || !hit;
    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = fill_addr_q;

    // Memory data is accepted only after the request has been up for a full cycle
    assign fill_done = (state_q == S_MEM_READ) && !first_q && !MEM_BUSYWAIT;
    assign line_we   = fill_done && !RESET;

    // Control FSM; reset aborts any fill in progress and invalidates every line
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            first_q     <= 1'b0;
            fill_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!hit) begin
                        fill_addr_q <= pc_blk;
                        mem_read_q  <= 1'b1;
                        first_q     <= 1'b1;
                        state_q     <= S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    first_q <= 1'b0;
                    if (fill_done) begin
                        mem_read_q        <= 1'b0;
                        valid_q[fill_idx] <= 1'b1;
                        state_q           <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    mem_read_q <= 1'b0;
                    first_q    <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage are never cleared; the valid bits guard them
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tag_q[fill_idx] <= fill_tag;
            for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
                data_q[fill_idx][OW'(k)] <= MEM_READDATA[32*k +: 32];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating event counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if ((state_q == S_IDLE) && !hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed table, hand-written corner sequences and a
// randomized fetch stream checked against a transaction-level cache model.
`timescale 1ns/1ps
module tb_icache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [9:0]   PC_ADDR;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    icache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC_ADDR      (PC_ADDR),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Instruction memory image, one word per 4-byte address
    logic [31:0] img [256];
    // Reference cache: which block address each line currently holds
    bit          mvalid [8];
    logic [2:0]  mtag   [8];

    int errors = 0;
    int checks = 0;
    int lat    = 2;
    int rd_cycles = 0;
    logic mr_s = 1'b0;

    typedef struct {
        logic [9:0] pc;
        int         lat;
        bit         miss;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory answers when the request has been up for lat cycles (at least two are spent anyway)
    task automatic drive_mem();
        mr_s = MEM_READ;
        if (MEM_READ) begin
            MEM_BUSYWAIT = (rd_cycles < lat - 1);
            for (int k = 0; k < 4; k++) MEM_READDATA[32*k +: 32] = img[{MEM_ADDRESS, 2'(k)}];
        end else begin
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = {4{32'hDEAD_BEEF}};
        end
    endtask

    task automatic settle();
        drive_mem();
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        rd_cycles = mr_s ? rd_cycles + 1 : 0;
        @(negedge CLK);
    endtask

    function automatic bit model_miss(input logic [9:0] pc);
        return !(mvalid[pc[6:4]] && mtag[pc[6:4]] == pc[9:7]);
    endfunction

    function automatic int read_cycles(input int lt);
        return (lt < 2) ? 2 : lt;
    endfunction

    // One CPU fetch: stall profile, refill address and returned word
    task automatic fetch(input logic [9:0] pc, input int lt, input bit exp_miss, input string nm);
        int busy_n;
        int mr_n;
        bit addr_bad;
        busy_n   = 0;
        mr_n     = 0;
        addr_bad = 0;
        PC_ADDR  = pc;
        lat      = lt;
        settle();
        check({nm, "_first_busy"}, 32'(BUSYWAIT), 32'(exp_miss));
        for (int c = 0; c < 40 && BUSYWAIT; c++) begin
            busy_n++;
            if (MEM_READ) begin
                mr_n++;
                if (MEM_ADDRESS !== pc[9:4]) addr_bad = 1;
            end
            step();
            settle();
        end
        check({nm, "_busy_cycles"}, 32'(busy_n), exp_miss ? 32'(read_cycles(lt) + 2) : 32'd0);
        check({nm, "_memread_cycles"}, 32'(mr_n), exp_miss ? 32'(read_cycles(lt)) : 32'd0);
        check({nm, "_mem_addr_bad"}, 32'(addr_bad), 32'd0);
        check({nm, "_instr"}, INSTRUCTION, img[pc[9:2]]);
        check({nm, "_memread_idle"}, 32'(MEM_READ), 32'd0);
        mvalid[pc[6:4]] = 1'b1;
        mtag[pc[6:4]]   = pc[9:7];
        step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        img[0] = 32'h0401_0005;
        model_reset();

        tbl[0] = '{10'h000, 5, 1'b1};
        tbl[1] = '{10'h004, 1, 1'b0};
        tbl[2] = '{10'h008, 1, 1'b0};
        tbl[3] = '{10'h00C, 1, 1'b0};
        tbl[4] = '{10'h080, 3, 1'b1};
        tbl[5] = '{10'h000, 2, 1'b1};
        tbl[6] = '{10'h3FC, 4, 1'b1};
        tbl[7] = '{10'h3F1, 1, 1'b0};
        tbl[8] = '{10'h084, 2, 1'b1};

        RESET        = 1'b1;
        PC_ADDR      = 10'h000;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        @(negedge CLK);
        step();
        settle();
        check("reset_mem_read", 32'(MEM_READ), 32'd0);
        check("reset_mem_addr", 32'(MEM_ADDRESS), 32'd0);
        check("reset_busy", 32'(BUSYWAIT), 32'd1);
        RESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            fetch(tbl[i].pc, tbl[i].lat, tbl[i].miss, $sformatf("tbl%0d", i));
        end
        PC_ADDR = 10'h000;
        lat     = 2;
        settle();
        check("tbl_w0_literal", (BUSYWAIT ? 32'h0 : INSTRUCTION), 32'h0);
        fetch(10'h000, 2, 1'b1, "refill0");
        PC_ADDR = 10'h000;
        settle();
        check("w0_literal", INSTRUCTION, 32'h0401_0005);

        // Reset on the third fill cycle while memory is already answering
        PC_ADDR = 10'h010;
        lat     = 2;
        settle();
        check("rstfill_miss", 32'(BUSYWAIT), 32'd1);
        step();
        settle();
        check("rstfill_mr", 32'(MEM_READ), 32'd1);
        step();
        settle();
        check("rstfill_mem_ready", 32'(MEM_BUSYWAIT), 32'd0);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        model_reset();
        settle();
        check("rstfill_abort_mr", 32'(MEM_READ), 32'd0);
        check("rstfill_still_miss", 32'(BUSYWAIT), 32'd1);
        fetch(10'h010, 3, 1'b1, "rstfill_refetch");

        // PC moves during a fill: the fill keeps its latched block
        PC_ADDR = 10'h020;
        lat     = 4;
        settle();
        check("pcchg_miss", 32'(BUSYWAIT), 32'(model_miss(10'h020)));
        step();
        PC_ADDR = 10'h0C4;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("pcchg_busy%0d", c), 32'(BUSYWAIT), 32'd1);
            if (c < 4) check($sformatf("pcchg_addr%0d", c), {MEM_READ, MEM_ADDRESS}, {1'b1, 6'h02});
            step();
        end
        mvalid[2] = 1'b1;
        mtag[2]   = 3'd0;
        fetch(10'h0C4, 2, model_miss(10'h0C4), "pcchg_new");
        fetch(10'h020, 2, model_miss(10'h020), "pcchg_old");

        // Random fetch stream against the reference model
        for (int n = 0; n < 80; n++) begin
            logic [9:0] pc;
            pc = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom)};
            fetch(pc, $urandom_range(1, 6), model_miss(pc), $sformatf("rnd%0d", n));
        end

`ifdef ICACHE_STATS_EN
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        model_reset();
        settle();
        check("stats_reset_hit", 32'(HIT_COUNT), 32'd0);
        check("stats_reset_miss", 32'(MISS_COUNT), 32'd0);
        fetch(10'h000, 3, 1'b1, "stats_miss");
        fetch(10'h004, 1, 1'b0, "stats_h1");
        fetch(10'h008, 1, 1'b0, "stats_h2");
        fetch(10'h00C, 1, 1'b0, "stats_h3");
        PC_ADDR = 10'h100;
        settle();
        check("stats_hit", 32'(HIT_COUNT), 32'd4);
        check("stats_miss", 32'(MISS_COUNT), 32'd1);
        force dut.miss_cnt_q = 16'hFFFF;
        #1;
        release dut.miss_cnt_q;
        fetch(10'h100, 2, 1'b1, "stats_sat");
        check("stats_miss_sat", 32'(MISS_COUNT), 32'h0000_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the CPU's PC output and the instruction memory. It returns the 32-bit instruction for the current PC.
- On a hit, the instruction is returned in the same cycle. On a miss, the CPU is stalled through BUSYWAIT while a whole block is fetched from the instruction memory over a read/busywait handshake.
- The CPU must hold its PC update while BUSYWAIT is high.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2); index width IW = log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4, 32-bit words per line (power of 2); offset width OW = log2(WORDS_PER_BLOCK).
- ADDR_W, 10, PC byte-address bits used; tag width TW = ADDR_W - 2 - OW - IW (default 3).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- PC_ADDR  in  ADDR_W  byte address from CPU (PC[ADDR_W-1:0]); bits [1:0] ignored
- INSTRUCTION  out  32  fetched instruction; valid when BUSYWAIT=0
- BUSYWAIT  out  1  stall request to CPU
- MEM_READ  out  1  block read request to instruction memory
- MEM_ADDRESS  out  ADDR_W-2-OW  block address (default 6 bits = PC[9:4])
- MEM_READDATA  in  32*WORDS_PER_BLOCK  block data; word k at bits [32k+31:32k]
- MEM_BUSYWAIT  in  1  memory busy; data valid on the cycle it is low after a request

Behaviour:
- RESET and CLK: RESET synchronous, active-high; clock CLK.
- On RESET: all valid bits=0, state=IDLE, MEM_READ=0, MEM_ADDRESS=0, latched fill address=0. Data and tag arrays are not cleared.
- Address split: offset = PC_ADDR[OW+1:2], index = next IW bits, tag = top TW bits.
- Hit (combinational) = valid[index] and tag_array[index]==tag.
- States: IDLE, MEM_READ, UPDATE.
- IDLE:
  - BUSYWAIT = !hit; INSTRUCTION = data[index] word[offset], combinational.
  - On a miss at a posedge: latch block address PC_ADDR[ADDR_W-1:OW+2] and go to MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS=latched block address, BUSYWAIT=1.
  - Stay while MEM_BUSYWAIT=1 or on the first cycle in the state.
  - On the first posedge with MEM_READ high for at least 1 full cycle and MEM_BUSYWAIT=0: write MEM_READDATA into line latched_index, set tag_array=latched_tag, valid=1, and go to UPDATE.
- UPDATE: MEM_READ=0, BUSYWAIT=1 for exactly one cycle, then IDLE. The refetch then hits.
- Hit latency: 0 cycles. Miss penalty: memory latency + 2 cycles (MEM_READ entry + UPDATE).
- INSTRUCTION is don't-care while BUSYWAIT=1. Bench must not check it then.
- If PC_ADDR changes during MEM_READ/UPDATE (CPU protocol violation), the fill still targets the latched address. After IDLE, hit/miss is re-evaluated on the new PC.
- RESET mid-fill:
  - Abort, with MEM_READ low after that edge.
  - The target line stays invalid, and no partial write occurs.
  - A late MEM_BUSYWAIT fall is ignored.
- RESET has priority over all transitions and the line write in the same edge.
- Conflict miss (same index, different tag) overwrites the line; no write-back, since the cache is read-only.
- Address wrap: PC above 2^ADDR_W aliases; upper PC bits are ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments on each posedge in IDLE with hit=1 and RESET=0.
  - MISS_COUNT increments on each IDLE->MEM_READ transition.
  - Both saturate at 16'hFFFF; an increment at saturation leaves the value unchanged.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset then PC_ADDR=0x000, memory returns block with word0=0x0401_0005 after 5 busy cycles -> BUSYWAIT high 7 cycles, MEM_READ high with MEM_ADDRESS=0, then INSTRUCTION=0x0401_0005 with BUSYWAIT=0.
- After fill, PC_ADDR=0x004, 0x008, 0x00C -> words 1..3 of the block each returned in the same cycle, BUSYWAIT=0, MEM_READ never asserted.
- PC_ADDR=0x080 (tag 1, index 0) after index-0 line loaded with tag 0 -> miss, MEM_ADDRESS=0x08. Then PC_ADDR=0x000 -> miss again (line replaced).
- RESET asserted on the 3rd cycle of a fill for PC_ADDR=0x010 -> MEM_READ=0 after that edge. Next fetch of 0x010 misses again (valid[1]=0).
- PC_ADDR=0x3FC (index 7, tag 7, offset 3) -> MEM_ADDRESS=0x3F; INSTRUCTION = MEM_READDATA[127:96].
- With ICACHE_STATS_EN, 1 miss followed by 3 hit cycles -> MISS_COUNT=1, HIT_COUNT=4 (including the refetch hit). With MISS_COUNT forced to 0xFFFF, a further miss leaves it at 0xFFFF.
